bram_stream_master: RTL and testbench
=====================================

Name: bram_stream_master

Overview:
- Initiator-side counterpart of the BRAM stream slave.
- Accepts one high-level transfer command (BRAM address, total beat count, direction).
- Splits the command into slave instruction words of at most MAX_BURST beats each.
- For each chunk it either forwards source data to the slave's input stream (write) or drains the slave's output stream into a destination stream (read), with one instruction in flight at a time.

Parameters:
- ADDR_W, 13, BRAM beat-address field width in the instruction word.
- LEN_W, 13, instruction length field width; the maximum encodable chunk is 2^LEN_W-1.
- MAX_BURST, 4096, maximum beats per issued instruction; must be in 1..2^LEN_W-1.
- TOTAL_W, 20, width of the command total-length field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_addr  in  ADDR_W  start beat address
- cmd_len  in  TOTAL_W  total beats
- cmd_write  in  1  1=write to BRAM, 0=read from BRAM
- cmd_valid  in  1  command handshake
- cmd_ready  out  1  command handshake
- m_instruct_tdata  out  64  {zeros[63:26], addr[25:13], length[12:0]}
- m_instruct_tvalid  out  1  instruction handshake
- m_instruct_tready  in  1  instruction handshake
- s_src_tdata  in  128  write data from upstream
- s_src_tvalid  in  1  write data handshake
- s_src_tready  out  1  write data handshake
- m_in_tdata  out  128  write data to slave input stream
- m_in_tvalid  out  1  write data handshake
- m_in_tready  in  1  write data handshake
- m_in_tkeep  out  16  constant 16'hffff
- m_in_tlast  out  1  last beat of chunk
- s_out_tdata  in  128  read data from slave output stream
- s_out_tvalid  in  1  read data handshake
- s_out_tready  out  1  read data handshake
- s_out_tlast  in  1  slave end-of-chunk marker
- m_dst_tdata  out  128  read data to downstream
- m_dst_tvalid  out  1  read data handshake
- m_dst_tready  in  1  read data handshake
- m_dst_tlast  out  1  last beat of whole command
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky tlast-mismatch flag; cleared by rst or by the next accepted command

Behaviour:
- Reset (rst sampled high at posedge): state IDLE, all counters 0.
  - Outputs at reset: cmd_ready=1; m_instruct_tvalid=0; done=0; err=0; m_instruct_tdata=0.
  - m_in_tvalid, s_src_tready, s_out_tready, m_dst_tvalid = 0.
  - Reset mid-transfer aborts immediately; no further instruction or beat is issued.
- FSM IDLE -> ISSUE -> DATA -> (ISSUE | DONE) -> IDLE.
- IDLE:
  - cmd_ready=1; on cmd_valid, latch addr, remaining=cmd_len, dir; clear err.
  - cmd_len=0 goes straight to DONE; no instruction is issued.
- ISSUE:
  - chunk = min(remaining, MAX_BURST).
  - Drive m_instruct_tvalid=1 with the registered {addr, chunk}; tdata is stable while valid is high and not ready.
  - On handshake: beat_cnt=chunk, go to DATA.
- DATA, write:
  - Combinational pass-through: m_in_tvalid=s_src_tvalid, s_src_tready=m_in_tready, m_in_tdata=s_src_tdata.
  - m_in_tlast=1 when beat_cnt==1.
  - Each transfer decrements beat_cnt.
  - When the last beat transfers: remaining-=chunk; addr+=chunk modulo 2^ADDR_W (wraps); go to ISSUE if remaining!=0, else DONE.
- DATA, read:
  - Pass-through s_out to m_dst.
  - m_dst_tlast=1 when beat_cnt==1 and remaining==chunk (final chunk).
  - If s_out_tlast disagrees with (beat_cnt==1) on any transferred beat, set err. Counting is unaffected: completion is determined by beat_cnt only.
- Unused direction drives valid/ready 0: a read never asserts s_src_tready; a write never asserts s_out_tready.
- DONE: done=1 for exactly one cycle, cmd_ready=0, then IDLE. A new command can be accepted one cycle after done.
- Next instruction is not issued until the previous chunk's last beat has transferred (single outstanding).
- Latency: command accept -> m_instruct_tvalid is 1 cycle; last data beat -> next m_instruct_tvalid or done is 1 cycle.
- Backpressure on any stream stalls only the counters; no beat is lost or duplicated.

Decomposition:
- Shared package bram_stream_pkg:
  - instruction-field constants INSTR_LEN_LSB=0, INSTR_ADDR_LSB=13, INSTR_W=64, DATA_W=128, KEEP_ALL=16'hffff
  - FSM state enum {IDLE, ISSUE, DATA, DONE}
  - function pack_instruct(addr, len)
- The slave side's field decode reuses the same package.
- One sub-module is natural: bram_burst_splitter (remaining/addr/chunk computation and the ISSUE handshake). The data pass-through and beat counting stay in the top.

Test Plan:
- Write, addr=0x010, len=5, MAX_BURST=4096:
  - one instruction, tdata=0x0000_0000_0002_0005;
  - 5 beats forwarded, tlast on the 5th;
  - done one cycle after the 5th beat.
- Write, len=10000 with MAX_BURST=4096:
  - instructions {0x000,4096}, {0x1000,4096}, {0x0000 wrapped... addr 8192 mod 8192 = 0x000, 1808};
  - tlast at beats 4096, 8192, 10000;
  - a single done.
- Read, addr=0x1FFE, len=3:
  - instruction addr=0x1FFE, len=3;
  - m_dst_tlast on 3rd beat;
  - slave tlast asserted early on beat 2 -> err=1, still 3 beats delivered, done pulses.
- Random tvalid/tready backpressure on every stream for a 300-beat write and read:
  - data order and count exact;
  - instruction tdata stable while stalled.
- cmd_len=0 -> no m_instruct_tvalid, done pulses 1 cycle after accept.
- rst asserted mid-DATA of a 100-beat write after 40 beats:
  - next cycle all valids/readys 0, cmd_ready=1, err=0;
  - a new command then executes normally.

Source files
------------

// File: rtl/bram_stream_pkg.sv
// ---------------------------------------------------------------------------
// bram_stream_pkg
// Shared definitions for the BRAM stream master/slave pair: instruction word
// layout, data/keep widths, the master FSM state type and the instruction
// packing helper. The slave's field decode uses the same constants so both
// sides agree on the word layout.
// ---------------------------------------------------------------------------
package bram_stream_pkg;

    localparam int INSTR_LEN_LSB  = 0;
    localparam int INSTR_ADDR_LSB = 13;
    localparam int INSTR_FIELD_W  = 13;
    localparam int INSTR_W        = 64;
    localparam int DATA_W         = 128;
    localparam int KEEP_W         = DATA_W / 8;
    localparam logic [KEEP_W-1:0] KEEP_ALL = 16'hffff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // {zeros, addr[25:13], length[12:0]}
    function automatic logic [INSTR_W-1:0] pack_instruct(
        input logic [INSTR_FIELD_W-1:0] addr,
        input logic [INSTR_FIELD_W-1:0] len
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[INSTR_ADDR_LSB +: INSTR_FIELD_W] = addr;
        w[INSTR_LEN_LSB  +: INSTR_FIELD_W] = len;
        return w;
    endfunction

endpackage

// File: rtl/bram_burst_splitter.sv
// ---------------------------------------------------------------------------
// bram_burst_splitter
// Tracks the remaining beat count and next BRAM address of a command, derives
// the current chunk (min(remaining, MAX_BURST)) and drives the instruction
// stream while the FSM is in ISSUE.
// Ports:
//   i_load/i_addr/i_len  latch a new command
//   i_issue              FSM is in ISSUE (instruction valid)
//   i_chunk_done         last beat of the current chunk transferred
//   o_chunk              beats in the current chunk
//   o_last_chunk         current chunk is the final one of the command
//   o_instr_*            instruction stream, o_instr_fire = handshake
// ---------------------------------------------------------------------------
module bram_burst_splitter
    import bram_stream_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int LEN_W     = 13,
    parameter int MAX_BURST = 4096,
    parameter int TOTAL_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [TOTAL_W-1:0] i_len,
    input  logic               i_issue,
    input  logic               i_chunk_done,
    output logic [LEN_W-1:0]   o_chunk,
    output logic               o_last_chunk,
    output logic [INSTR_W-1:0] o_instr_tdata,
    output logic               o_instr_tvalid,
    input  logic               i_instr_tready,
    output logic               o_instr_fire
);

    localparam logic [TOTAL_W-1:0] LP_MAX_T = TOTAL_W'(MAX_BURST);
    localparam logic [LEN_W-1:0]   LP_MAX_L = LEN_W'(MAX_BURST);

    logic [ADDR_W-1:0]  r_addr;
    logic [TOTAL_W-1:0] r_remaining;
    logic [LEN_W-1:0]   w_chunk;

    // Chunk is derived from registered state only, so the instruction word
    // cannot change while it waits for tready.
    assign w_chunk      = (r_remaining > LP_MAX_T) ? LP_MAX_L : r_remaining[LEN_W-1:0];
    assign o_chunk      = w_chunk;
    assign o_last_chunk = (r_remaining <= LP_MAX_T);

    assign o_instr_tdata  = pack_instruct(INSTR_FIELD_W'(r_addr), INSTR_FIELD_W'(w_chunk));
    assign o_instr_tvalid = i_issue;
    assign o_instr_fire   = i_issue & i_instr_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_addr;
            r_remaining <= i_len;
        end else if (i_chunk_done) begin
            // address wraps modulo 2^ADDR_W
            r_addr      <= r_addr + ADDR_W'(w_chunk);
            r_remaining <= r_remaining - TOTAL_W'(w_chunk);
        end
    end

endmodule

// File: rtl/bram_stream_master.sv
// ---------------------------------------------------------------------------
// bram_stream_master
// Initiator for the BRAM stream slave. Takes one transfer command, splits it
// into instructions of at most MAX_BURST beats and, per chunk, forwards
// s_src -> m_in (write) or s_out -> m_dst (read). One instruction in flight.
// Ports:
//   cmd_*          command (addr, total beats, direction) handshake
//   m_instruct_*   instruction words to the slave
//   s_src_*/m_in_* write data path (combinational pass-through)
//   s_out_*/m_dst_* read data path (combinational pass-through)
//   done           one-cycle completion pulse
//   err            sticky: slave tlast disagreed with the expected chunk end
// ---------------------------------------------------------------------------
module bram_stream_master
    import bram_stream_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int LEN_W     = 13,
    parameter int MAX_BURST = 4096,
    parameter int TOTAL_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [TOTAL_W-1:0] cmd_len,
    input  logic               cmd_write,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [INSTR_W-1:0] m_instruct_tdata,
    output logic               m_instruct_tvalid,
    input  logic               m_instruct_tready,
    input  logic [DATA_W-1:0]  s_src_tdata,
    input  logic               s_src_tvalid,
    output logic               s_src_tready,
    output logic [DATA_W-1:0]  m_in_tdata,
    output logic               m_in_tvalid,
    input  logic               m_in_tready,
    output logic [KEEP_W-1:0]  m_in_tkeep,
    output logic               m_in_tlast,
    input  logic [DATA_W-1:0]  s_out_tdata,
    input  logic               s_out_tvalid,
    output logic               s_out_tready,
    input  logic               s_out_tlast,
    output logic [DATA_W-1:0]  m_dst_tdata,
    output logic               m_dst_tvalid,
    input  logic               m_dst_tready,
    output logic               m_dst_tlast,
    output logic               done,
    output logic               err
);

    state_t           r_state;
    logic [LEN_W-1:0] r_beat_cnt;
    logic             r_write;
    logic             r_err;

    logic             w_load;
    logic             w_data_wr;
    logic             w_data_rd;
    logic             w_beat_fire;
    logic             w_beat_last;
    logic             w_chunk_done;
    logic [LEN_W-1:0] w_chunk;
    logic             w_last_chunk;
    logic             w_instr_fire;

    assign w_load       = (r_state == IDLE) & cmd_valid;
    assign w_data_wr    = (r_state == DATA) &  r_write;
    assign w_data_rd    = (r_state == DATA) & ~r_write;
    assign w_beat_fire  = (w_data_wr & s_src_tvalid & m_in_tready) |
                          (w_data_rd & s_out_tvalid & m_dst_tready);
    assign w_beat_last  = (r_beat_cnt == LEN_W'(1));
    assign w_chunk_done = w_beat_fire & w_beat_last;

    bram_burst_splitter #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST),
        .TOTAL_W   (TOTAL_W)
    ) u_split (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_load),
        .i_addr         (cmd_addr),
        .i_len          (cmd_len),
        .i_issue        (r_state == ISSUE),
        .i_chunk_done   (w_chunk_done),
        .o_chunk        (w_chunk),
        .o_last_chunk   (w_last_chunk),
        .o_instr_tdata  (m_instruct_tdata),
        .o_instr_tvalid (m_instruct_tvalid),
        .i_instr_tready (m_instruct_tready),
        .o_instr_fire   (w_instr_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_write    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_write <= cmd_write;
                        r_state <= (cmd_len == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_instr_fire) begin
                        r_beat_cnt <= w_chunk;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat_fire) begin
                        r_beat_cnt <= r_beat_cnt - LEN_W'(1);
                        if (w_beat_last)
                            r_state <= w_last_chunk ? DONE : ISSUE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Completion is driven by beat_cnt alone; a disagreeing slave tlast is
    // only flagged.
    always_ff @(posedge clk) begin
        if (rst || w_load)
            r_err <= 1'b0;
        else if (w_data_rd && w_beat_fire && (s_out_tlast != w_beat_last))
            r_err <= 1'b1;
    end

    assign cmd_ready = (r_state == IDLE);
    assign done      = (r_state == DONE);
    assign err       = r_err;

    // Inactive direction keeps its valid/ready low.
    assign m_in_tdata   = s_src_tdata;
    assign m_in_tvalid  = w_data_wr & s_src_tvalid;
    assign s_src_tready = w_data_wr & m_in_tready;
    assign m_in_tkeep   = KEEP_ALL;
    assign m_in_tlast   = w_data_wr & w_beat_last;

    assign m_dst_tdata  = s_out_tdata;
    assign m_dst_tvalid = w_data_rd & s_out_tvalid;
    assign s_out_tready = w_data_rd & m_dst_tready;
    assign m_dst_tlast  = w_data_rd & w_beat_last & w_last_chunk;

endmodule

// File: tb/tb_bram_stream_master.sv
module tb_bram_stream_master;

    localparam int MAXB = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic [12:0]  cmd_addr;
    logic [19:0]  cmd_len;
    logic         cmd_write, cmd_valid, cmd_ready;
    logic [63:0]  m_instruct_tdata;
    logic         m_instruct_tvalid, m_instruct_tready;
    logic [127:0] s_src_tdata, m_in_tdata, s_out_tdata, m_dst_tdata;
    logic         s_src_tvalid, s_src_tready, m_in_tvalid, m_in_tready, m_in_tlast;
    logic [15:0]  m_in_tkeep;
    logic         s_out_tvalid, s_out_tready, s_out_tlast;
    logic         m_dst_tvalid, m_dst_tready, m_dst_tlast;
    logic         done, err;

    bram_stream_master #(.ADDR_W(13), .LEN_W(13), .MAX_BURST(MAXB), .TOTAL_W(20)) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_instruct_tdata(m_instruct_tdata), .m_instruct_tvalid(m_instruct_tvalid),
        .m_instruct_tready(m_instruct_tready),
        .s_src_tdata(s_src_tdata), .s_src_tvalid(s_src_tvalid), .s_src_tready(s_src_tready),
        .m_in_tdata(m_in_tdata), .m_in_tvalid(m_in_tvalid), .m_in_tready(m_in_tready),
        .m_in_tkeep(m_in_tkeep), .m_in_tlast(m_in_tlast),
        .s_out_tdata(s_out_tdata), .s_out_tvalid(s_out_tvalid), .s_out_tready(s_out_tready),
        .s_out_tlast(s_out_tlast),
        .m_dst_tdata(m_dst_tdata), .m_dst_tvalid(m_dst_tvalid), .m_dst_tready(m_dst_tready),
        .m_dst_tlast(m_dst_tlast),
        .done(done), .err(err)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit mon_en, cfg_write, cfg_bp, cmd_acc, pend_acc, prev_stall;
    int cfg_len, cfg_tag, cfg_early;
    int wr_idx, rd_idx, src_idx, slv_idx, slv_left, done_cnt, instr_cnt, pend;
    logic [63:0] prev_td;
    logic [63:0] exp_instr[$];
    logic [63:0] instr_log[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] beat_data(input int tag, input int idx);
        return {tag, idx, ~idx, tag ^ (idx * 32'h9E3779B1)};
    endfunction

    // Per-cycle comparison against the command-level model.
    task automatic monitor();
        int k;
        if (pend == 1) chk("done_latency", 128'(done), 128'(1));
        if (pend == 2) chk("instr_latency", 128'(m_instruct_tvalid), 128'(1));
        if (pend_acc) chk("err_cleared", 128'(err), 128'(0));
        pend = 0;
        pend_acc = 0;

        if (prev_stall) begin
            chk("instr_hold_valid", 128'(m_instruct_tvalid), 128'(1));
            chk("instr_stable", 128'(m_instruct_tdata), 128'(prev_td));
        end
        if (m_instruct_tvalid && m_instruct_tready) begin
            instr_log.push_back(m_instruct_tdata);
            chk("instr_after_beats", 128'(wr_idx + rd_idx), 128'(instr_cnt * MAXB));
            if (exp_instr.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL instr_extra: got %h expected none", m_instruct_tdata);
            end else
                chk("instr_tdata", 128'(m_instruct_tdata), 128'(exp_instr.pop_front()));
            instr_cnt++;
        end
        prev_stall = m_instruct_tvalid && !m_instruct_tready;
        prev_td    = m_instruct_tdata;

        if (m_in_tvalid && m_in_tready) begin
            k = wr_idx + 1;
            chk("wr_data", m_in_tdata, beat_data(cfg_tag, wr_idx));
            chk("wr_tlast", 128'(m_in_tlast), 128'((k % MAXB == 0) || (k == cfg_len)));
            chk("wr_tkeep", 128'(m_in_tkeep), 128'(16'hffff));
            wr_idx = k;
            if ((k % MAXB == 0) || (k == cfg_len)) pend = (k == cfg_len) ? 1 : 2;
        end
        if (m_dst_tvalid && m_dst_tready) begin
            k = rd_idx + 1;
            chk("rd_data", m_dst_tdata, beat_data(cfg_tag, rd_idx));
            chk("rd_tlast", 128'(m_dst_tlast), 128'(k == cfg_len));
            rd_idx = k;
            if ((k % MAXB == 0) || (k == cfg_len)) pend = (k == cfg_len) ? 1 : 2;
        end

        if (cfg_write) begin
            chk("wr_no_sout_ready", 128'(s_out_tready), 128'(0));
            chk("wr_no_dst_valid", 128'(m_dst_tvalid), 128'(0));
        end else begin
            chk("rd_no_src_ready", 128'(s_src_tready), 128'(0));
            chk("rd_no_in_valid", 128'(m_in_tvalid), 128'(0));
        end

        if (done) begin
            done_cnt++;
            chk("done_cmd_ready", 128'(cmd_ready), 128'(0));
        end
        if (cmd_valid && cmd_ready) begin
            pend = (cfg_len == 0) ? 1 : 2;
            pend_acc = 1;
        end
    endtask

    // One clock: sample/compare at negedge, drive stimulus 1 after posedge.
    task automatic cycle();
        @(negedge clk);
        if (mon_en) monitor();
        if (cmd_valid && cmd_ready) cmd_acc = 1;
        if (s_src_tvalid && s_src_tready) src_idx++;
        if (s_out_tvalid && s_out_tready) begin slv_idx++; slv_left--; end
        if (m_instruct_tvalid && m_instruct_tready && !cfg_write)
            slv_left += int'(m_instruct_tdata[12:0]);
        @(posedge clk); #1;
        if (cmd_acc) cmd_valid = 1'b0;
        m_instruct_tready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_in_tready       = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_dst_tready      = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        s_src_tvalid = cfg_write && (src_idx < cfg_len) && (!cfg_bp || $urandom_range(0, 1) == 1);
        s_src_tdata  = beat_data(cfg_tag, src_idx);
        s_out_tvalid = (slv_left > 0) && (!cfg_bp || $urandom_range(0, 1) == 1);
        s_out_tdata  = beat_data(cfg_tag, slv_idx);
        s_out_tlast  = (cfg_early != 0) ? (slv_idx + 1 == cfg_early) : (slv_left == 1);
    endtask

    task automatic run_cmd(input int addr, input int len, input bit wr, input bit bp,
                           input int early, input int tag, input bit exp_err, input int abort_at);
        int rem, a, c, n, budget;
        logic [63:0] e;
        exp_instr.delete();
        instr_log.delete();
        rem = len;
        a = addr;
        while (rem > 0) begin
            c = (rem > MAXB) ? MAXB : rem;
            e = '0;
            e[25:13] = a[12:0];
            e[12:0]  = c[12:0];
            exp_instr.push_back(e);
            rem -= c;
            a = (a + c) % 8192;
        end
        cfg_write = wr; cfg_bp = bp; cfg_len = len; cfg_tag = tag; cfg_early = early;
        wr_idx = 0; rd_idx = 0; src_idx = 0; slv_idx = 0; slv_left = 0;
        done_cnt = 0; instr_cnt = 0; pend = 0; pend_acc = 0; prev_stall = 0; cmd_acc = 0;
        cmd_addr = 13'(addr); cmd_len = 20'(len); cmd_write = wr; cmd_valid = 1'b1;
        mon_en = 1;
        budget = len * 8 + 50;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            cycle();
            n++;
            if (abort_at != 0 && wr_idx >= abort_at) break;
        end
        if (abort_at != 0) begin
            mon_en = 0;
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_instr_valid", 128'(m_instruct_tvalid), 128'(0));
            chk("rst_in_valid", 128'(m_in_tvalid), 128'(0));
            chk("rst_src_ready", 128'(s_src_tready), 128'(0));
            chk("rst_out_ready", 128'(s_out_tready), 128'(0));
            chk("rst_dst_valid", 128'(m_dst_tvalid), 128'(0));
            chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
            chk("rst_err", 128'(err), 128'(0));
            chk("rst_done", 128'(done), 128'(0));
            rst = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                chk("post_rst_no_instr", 128'(m_instruct_tvalid), 128'(0));
                chk("post_rst_no_beat", 128'(m_in_tvalid), 128'(0));
            end
            return;
        end
        repeat (4) cycle();
        mon_en = 0;
        chk("done_count", 128'(done_cnt), 128'(1));
        chk("beat_count", 128'(wr ? wr_idx : rd_idx), 128'(len));
        chk("instr_left", 128'(exp_instr.size()), 128'(0));
        chk("err_final", 128'(err), 128'(exp_err));
        chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
    endtask

    initial begin
        rst = 1'b1;
        cmd_addr = '0; cmd_len = '0; cmd_write = 1'b0; cmd_valid = 1'b0;
        m_instruct_tready = 1'b0; m_in_tready = 1'b0; m_dst_tready = 1'b0;
        s_src_tdata = '0; s_src_tvalid = 1'b0; s_out_tdata = '0; s_out_tvalid = 1'b0;
        s_out_tlast = 1'b0;
        mon_en = 0; cfg_write = 0; cfg_bp = 0; cfg_len = 0; cfg_tag = 0; cfg_early = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("reset_instr_valid", 128'(m_instruct_tvalid), 128'(0));
        chk("reset_instr_tdata", 128'(m_instruct_tdata), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_err", 128'(err), 128'(0));
        chk("reset_in_valid", 128'(m_in_tvalid), 128'(0));
        chk("reset_src_ready", 128'(s_src_tready), 128'(0));
        chk("reset_out_ready", 128'(s_out_tready), 128'(0));
        chk("reset_dst_valid", 128'(m_dst_tvalid), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // short write, single chunk
        run_cmd(32'h010, 5, 1, 0, 0, 1, 0, 0);
        chk("lit_t1_instr", 128'(instr_log[0]), 128'h0000_0000_0002_0005);
        chk("lit_t1_ninstr", 128'(instr_log.size()), 128'(1));

        // three chunks, address wraps to 0 on the third
        run_cmd(32'h000, 10000, 1, 0, 0, 2, 0, 0);
        chk("lit_t2_instr0", 128'(instr_log[0]), 128'h0000_0000_0000_1000);
        chk("lit_t2_instr1", 128'(instr_log[1]), 128'h0000_0000_0200_1000);
        chk("lit_t2_instr2", 128'(instr_log[2]), 128'h0000_0000_0000_0710);

        // read at top of address space, slave tlast early on beat 2
        run_cmd(32'h1FFE, 3, 0, 0, 2, 3, 1, 0);
        chk("lit_t3_instr", 128'(instr_log[0]), 128'h0000_0000_03FF_C003);

        // clean read clears the sticky error
        run_cmd(32'h100, 3, 0, 0, 0, 4, 0, 0);

        // backpressure on every stream
        run_cmd(32'h055, 300, 1, 1, 0, 5, 0, 0);
        run_cmd(32'h1F00, 300, 0, 1, 0, 6, 0, 0);

        // zero-length command: no instruction
        run_cmd(32'h123, 0, 1, 0, 0, 7, 0, 0);
        chk("lit_len0_ninstr", 128'(instr_log.size()), 128'(0));

        // reset after 40 beats of a 100-beat write, then a normal command
        run_cmd(32'h200, 100, 1, 0, 0, 8, 0, 40);
        run_cmd(32'h040, 7, 1, 1, 0, 9, 0, 0);
        chk("lit_t9_instr", 128'(instr_log[0]), 128'h0000_0000_0008_0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
